// File: rtl/quantized_tile_accumulator.sv
// Dequantizes per-tile int partial products with their per-tile scale, accumulates IN_DEPTH
// tiles, adds optional bias, rounds half toward +inf and saturates to a fixed-point tile.
//   state  | meaning
//   ACCUM  | accept tiles; acc += tile * scale
//   FINAL  | wait for bias (HAS_BIAS=1), round/saturate into data_out
//   OUTPUT | hold result until downstream accepts, then clear accumulators
module quantized_tile_accumulator #(
   parameter int OUT_ROWS         = 2,
   parameter int OUT_COLUMNS      = 2,
   parameter int IN_DEPTH         = 3,
   parameter int PROD_WIDTH       = 17,
   parameter int SCALE_WIDTH      = 16,
   parameter int SCALE_FRAC_WIDTH = 8,
   parameter int HAS_BIAS         = 0,
   parameter int BIAS_WIDTH       = 8,
   parameter int BIAS_FRAC_WIDTH  = 4,
   parameter int OUT_WIDTH        = 8,
   parameter int OUT_FRAC_WIDTH   = 4
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [PROD_WIDTH*OUT_ROWS*OUT_COLUMNS-1:0]    tile_in,
   input  logic [SCALE_WIDTH-1:0]                        scale_in,
   input  logic                                          tile_valid,
   output logic                                          tile_ready,
   input  logic [BIAS_WIDTH*OUT_ROWS*OUT_COLUMNS-1:0]    bias,
   input  logic                                          bias_valid,
   output logic                                          bias_ready,
   output logic [OUT_WIDTH*OUT_ROWS*OUT_COLUMNS-1:0]     data_out,
   output logic                                          data_out_valid,
   input  logic                                          data_out_ready,
   output logic                                          overflow
);

   localparam int NE        = OUT_ROWS * OUT_COLUMNS;
   localparam int ACC_WIDTH = PROD_WIDTH + SCALE_WIDTH + 1 + $clog2(IN_DEPTH);
   // two guard bits: bias addition and rounding offset can never wrap
   localparam int SUM_WIDTH = ACC_WIDTH + 2;
   localparam int SH        = SCALE_FRAC_WIDTH - OUT_FRAC_WIDTH;
   localparam int BSH       = SCALE_FRAC_WIDTH - BIAS_FRAC_WIDTH;
   localparam int CNT_WIDTH = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
   localparam bit HAS_BIAS_B = (HAS_BIAS != 0);

   localparam logic [CNT_WIDTH-1:0]        CNT_LAST = CNT_WIDTH'(IN_DEPTH - 1);
   localparam logic signed [SUM_WIDTH-1:0] RND  =
      (SH > 0) ? (SUM_WIDTH'(1) << ((SH > 0) ? SH - 1 : 0)) : '0;
   localparam logic signed [SUM_WIDTH-1:0] OMAX = (SUM_WIDTH'(1) << (OUT_WIDTH - 1)) - SUM_WIDTH'(1);
   localparam logic signed [SUM_WIDTH-1:0] OMIN = -(SUM_WIDTH'(1) << (OUT_WIDTH - 1));

   typedef enum logic [1:0] {
      S_ACCUM  = 2'd0,
      S_FINAL  = 2'd1,
      S_OUTPUT = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;
   logic signed [ACC_WIDTH-1:0]     acc_q [NE];
   logic signed [ACC_WIDTH-1:0]     acc_d [NE];
   logic [OUT_WIDTH*NE-1:0]         data_out_q, data_out_d;
   logic                            overflow_q, overflow_d;

   logic signed [ACC_WIDTH-1:0]     tile_ext [NE];
   logic signed [ACC_WIDTH-1:0]     scale_ext;
   logic signed [ACC_WIDTH-1:0]     prod     [NE];
   logic signed [SUM_WIDTH-1:0]     bias_sh  [NE];
   logic signed [SUM_WIDTH-1:0]     sum      [NE];
   logic signed [SUM_WIDTH-1:0]     rnd      [NE];
   logic [OUT_WIDTH*NE-1:0]         sat_vec;
   logic [NE-1:0]                   sat_flag;

   // scale is unsigned: zero-extend before the signed multiply
   assign scale_ext = ACC_WIDTH'($signed({1'b0, scale_in}));

   always_comb begin
      sat_vec  = '0;
      sat_flag = '0;
      for (int i = 0; i < NE; i++) begin
         tile_ext[i] = ACC_WIDTH'($signed(tile_in[i*PROD_WIDTH +: PROD_WIDTH]));
         prod[i]     = tile_ext[i] * scale_ext;
         if (HAS_BIAS_B)
            bias_sh[i] = SUM_WIDTH'($signed(bias[i*BIAS_WIDTH +: BIAS_WIDTH])) <<< BSH;
         else
            bias_sh[i] = '0;
         sum[i] = SUM_WIDTH'(acc_q[i]) + bias_sh[i];
         rnd[i] = (sum[i] + RND) >>> SH;
         if (rnd[i] > OMAX) begin
            sat_vec[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(OMAX);
            sat_flag[i] = 1'b1;
         end else if (rnd[i] < OMIN) begin
            sat_vec[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(OMIN);
            sat_flag[i] = 1'b1;
         end else begin
            sat_vec[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(rnd[i]);
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      acc_d          = acc_q;
      data_out_d     = data_out_q;
      overflow_d     = overflow_q;
      tile_ready     = 1'b0;
      bias_ready     = 1'b0;
      data_out_valid = 1'b0;
      case (state_q)
         S_ACCUM: begin
            tile_ready = 1'b1;
            if (tile_valid) begin
               for (int i = 0; i < NE; i++) acc_d[i] = acc_q[i] + prod[i];
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = S_FINAL;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_FINAL: begin
            bias_ready = HAS_BIAS_B;
            if (!HAS_BIAS_B || bias_valid) begin
               data_out_d = sat_vec;
               overflow_d = |sat_flag;
               state_d    = S_OUTPUT;
            end
         end
         S_OUTPUT: begin
            data_out_valid = 1'b1;
            if (data_out_ready) begin
               for (int i = 0; i < NE; i++) acc_d[i] = '0;
               state_d = S_ACCUM;
            end
         end
         default: state_d = S_ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_ACCUM;
         cnt_q      <= '0;
         data_out_q <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < NE; i++) acc_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         data_out_q <= data_out_d;
         overflow_q <= overflow_d;
         for (int i = 0; i < NE; i++) acc_q[i] <= acc_d[i];
      end
   end

   assign data_out = data_out_q;
   assign overflow = overflow_q;

endmodule
